// File: rtl/mips_dump_pkg.sv
// Shared types and constants for the MIPS machine-state dumper.
package mips_dump_pkg;

  // Dump sequencer states: register phase, memory phase, then a one-cycle DONE.
  typedef enum logic [2:0] {
    IDLE,
    REG_REQ,
    REG_WAIT,
    REG_OUT,
    MEM_REQ,
    MEM_WAIT,
    MEM_OUT,
    DONE
  } dump_state_e;

  // Record source tag carried on outIsMem.
  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Default read latency of reg_file / data_mem.
  localparam int unsigned RD_LATENCY_DEF = 1;

  // Byte address of the idx-th dumped word; wraps modulo 2^32.
  function automatic logic [31:0] mem_word_addr(input logic [31:0] base,
                                                input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/mips_state_dumper_if.sv
// Record stream from the dumper to the bench/host: {address, data, source}
// qualified by a valid/ready handshake.
interface mips_state_dumper_if;
  logic        outValid;
  logic        outReady;
  logic [31:0] outAddr;
  logic [31:0] outData;
  logic        outIsMem;

  modport master (
    output outValid,
    output outAddr,
    output outData,
    output outIsMem,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outAddr,
    input  outData,
    input  outIsMem,
    output outReady
  );
endinterface

// File: rtl/dump_out_reg.sv
// Output holding register for dump records: loads a captured word, holds it
// stable with outValid=1 until the sink accepts it, then drops valid.
module dump_out_reg
  import mips_dump_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_is_mem,
  mips_state_dumper_if.master rec
);

  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        is_mem_q;

  // Record register: load on capture, clear valid on handshake, else hold.
  // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      is_mem_q <= SRC_REG;
    end else if (load) begin
      valid_q  <= 1'b1;
      addr_q   <= load_addr;
      data_q   <= load_data;
      is_mem_q <= load_is_mem;
    end else if (valid_q && rec.outReady) begin
      valid_q  <= 1'b0;
    end
  end

  assign rec.outValid = valid_q;
  assign rec.outAddr  = addr_q;
  assign rec.outData  = data_q;
  assign rec.outIsMem = is_mem_q;

endmodule

// File: rtl/mips_state_dumper.sv
// Post-run machine-state reader: freezes the processor, walks every register
// file entry and then a window of data memory, streaming one record per word.
module mips_state_dumper
  import mips_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter logic [31:0] MEM_BASE   = 32'h0,
  parameter int unsigned MEM_WORDS  = 64,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        dumpStart,
  output logic        dumpBusy,
  output logic        holdProc,
  output logic        dumpDone,
  output logic [4:0]  regRdAddr,
  input  logic [31:0] regRdData,
  output logic [31:0] memRdAddr,
  output logic        memRdEn,
  input  logic [31:0] memRdData,
  mips_state_dumper_if.master rec
);

  localparam int unsigned REG_IDX_W = $clog2(NUM_REGS + 1);
  localparam int unsigned MEM_IDX_W = $clog2(MEM_WORDS + 1);
  localparam int unsigned IDX_W     = (REG_IDX_W > MEM_IDX_W) ? REG_IDX_W : MEM_IDX_W;
  localparam int unsigned LAT_W     = $clog2(RD_LATENCY + 1);

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RD_LATENCY - 1);

  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic        handshake;
  logic        load;
  logic [31:0] mem_addr;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic        cap_is_mem;

  assign handshake = rec.outValid && rec.outReady;
  assign mem_addr  = mem_word_addr(MEM_BASE, 32'(idx_q));

  // State, index and latency counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic: request, wait out the read latency, present, advance.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    load       = 1'b0;
    cap_addr   = 32'(idx_q);
    cap_data   = regRdData;
    cap_is_mem = SRC_REG;

    unique case (state_q)
      IDLE: begin
        if (dumpStart) begin
          state_d = REG_REQ;
          idx_d   = '0;
        end
      end
      REG_REQ: begin
        lat_d   = '0;
        state_d = REG_WAIT;
      end
      REG_WAIT: begin
        if (lat_q == LAST_LAT) begin
          load    = 1'b1;
          state_d = REG_OUT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      REG_OUT: begin
        if (handshake) begin
          if (idx_q != LAST_REG) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = REG_REQ;
          end else if (MEM_WORDS == 0) begin
            state_d = DONE;
          end else begin
            idx_d   = '0;
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        lat_d   = '0;
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        cap_addr   = mem_addr;
        cap_data   = memRdData;
        cap_is_mem = SRC_MEM;
        if (lat_q == LAST_LAT) begin
          load    = 1'b1;
          state_d = MEM_OUT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      MEM_OUT: begin
        if (handshake) begin
          if (idx_q != LAST_MEM) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = MEM_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-port drive: addresses held from request through handshake, zero otherwise.
  always_comb begin
    regRdAddr = '0;
    memRdAddr = '0;
    memRdEn   = 1'b0;
    unique case (state_q)
      REG_REQ, REG_WAIT, REG_OUT: regRdAddr = 5'(idx_q);
      MEM_REQ, MEM_WAIT, MEM_OUT: begin
        memRdAddr = mem_addr;
        memRdEn   = 1'b1;
      end
      default: ;
    endcase
  end

  assign dumpBusy = (state_q != IDLE);
  assign holdProc = dumpBusy;
  assign dumpDone = (state_q == DONE);

  dump_out_reg u_out_reg (
    .clk         (clk),
    .resetN      (resetN),
    .load        (load),
    .load_addr   (cap_addr),
    .load_data   (cap_data),
    .load_is_mem (cap_is_mem),
    .rec         (rec)
  );

endmodule
